pkt_capture_ctrl: RTL and testbench

- Capture engine that consumes the host-programmed buffer address and length and the control start bit, and produces the 2-bit status fed back into the H2F status/control register block.
- Accepts one packet from a 32-bit streaming source and writes it word by word to memory through an Avalon-MM write master.
- Sits between the packet stream, the memory interconnect, and the host register block.

---
 rtl/capture_pkg.sv | 33 +++
 rtl/pkt_capture_ctrl.sv | 156 +++++++++++++++
 tb/tb_pkt_capture_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types for the packet capture engine: internal FSM encoding and the
// 2-bit status codes reported to the host register block.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        FLUSH,
        DONE
    } cap_state_t;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ARMED   = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    // FLUSH is still "capturing" from the host's point of view.
    function automatic logic [1:0] state_code(input cap_state_t s);
        logic [1:0] code;
        code = ST_IDLE;
        case (s)
            IDLE:    code = ST_IDLE;
            ARMED:   code = ST_ARMED;
            CAPTURE: code = ST_CAPTURE;
            FLUSH:   code = ST_CAPTURE;
            DONE:    code = ST_DONE;
            default: code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pkt_capture_ctrl.sv
// Single-packet capture engine: takes one packet from a streaming source and
// writes it word by word into a host-programmed buffer via an Avalon-MM master.
module pkt_capture_ctrl
    import capture_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] base_addr,
    input  logic [N-1:0] max_len,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [N-1:0] st_data,
    input  logic         st_sop,
    input  logic         st_eop,
    output logic [N-1:0] m_address,
    output logic         m_write,
    output logic [N-1:0] m_writedata,
    input  logic         m_waitrequest,
    output logic [1:0]   state,
    output logic [N-1:0] bytes_written,
    output logic         overflow
);

    localparam int WB = N / 8;
    localparam int LG = $clog2(WB);
    localparam logic [N-1:0] WB_BYTES = N'(WB);

    cap_state_t cur, nxt;

    logic [N-1:0] base_reg;
    logic [N-1:0] cap_words;
    logic [N-1:0] offset;
    logic         abort_pend;
    logic         abort_pend_nxt;

    logic         take_word;
    logic         drop_word;
    logic         arm;
    logic         wr_done;
    logic         can_retire;
    logic         buf_full;
    logic [N-1:0] max_words;

    assign wr_done    = m_write && !m_waitrequest;
    assign can_retire = !m_write || !m_waitrequest;
    assign buf_full   = (offset == cap_words);
    assign max_words  = max_len >> LG;
    assign state      = state_code(cur);

    // State register plus the "abort waiting for a stalled write" flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= IDLE;
            abort_pend <= 1'b0;
        end else begin
            cur        <= nxt;
            abort_pend <= abort_pend_nxt;
        end
    end

    // Next-state and stream handshake. An abort outranks everything and only
    // retires once the holding stage is empty.
    always_comb begin
        nxt            = cur;
        abort_pend_nxt = abort_pend;
        st_ready       = 1'b0;
        take_word      = 1'b0;
        drop_word      = 1'b0;
        arm            = 1'b0;

        if (abort || abort_pend) begin
            if (can_retire) begin
                nxt            = IDLE;
                abort_pend_nxt = 1'b0;
            end else begin
                abort_pend_nxt = 1'b1;
            end
        end else begin
            case (cur)
                IDLE, DONE: begin
                    if (start) begin
                        arm = 1'b1;
                        nxt = (max_words == '0) ? DONE : ARMED;
                    end
                end
                ARMED: begin
                    st_ready = 1'b1;
                    if (st_valid && st_sop) begin
                        take_word = 1'b1;
                        nxt       = st_eop ? FLUSH : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (buf_full) begin
                        st_ready  = 1'b1;
                        drop_word = st_valid;
                    end else begin
                        st_ready  = can_retire;
                        take_word = st_valid && can_retire;
                    end
                    if (st_valid && st_ready && st_eop) begin
                        nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (can_retire) begin
                        nxt = DONE;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // Buffer bookkeeping and the single-entry write holding stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_reg      <= '0;
            cap_words     <= '0;
            offset        <= '0;
            bytes_written <= '0;
            overflow      <= 1'b0;
            m_write       <= 1'b0;
            m_address     <= '0;
            m_writedata   <= '0;
        end else begin
            if (arm) begin
                base_reg      <= base_addr;
                cap_words     <= max_words;
                offset        <= '0;
                bytes_written <= '0;
                overflow      <= 1'b0;
            end else if (wr_done) begin
                bytes_written <= bytes_written + WB_BYTES;
            end

            if (take_word) begin
                m_write     <= 1'b1;
                m_address   <= base_reg + (offset << LG);
                m_writedata <= st_data;
                offset      <= offset + 1'b1;
            end else if (wr_done) begin
                m_write <= 1'b0;
            end

            if (drop_word) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Directed self-checking bench for pkt_capture_ctrl: capture, junk filtering,
// backpressure, overflow, abort and reset scenarios.
module tb_pkt_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [31:0] max_len;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_data;
    logic        st_sop;
    logic        st_eop;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [1:0]  state;
    logic [31:0] bytes_written;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    pkt_capture_ctrl #(.N(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .max_len(max_len),
        .st_valid(st_valid),
        .st_ready(st_ready),
        .st_data(st_data),
        .st_sop(st_sop),
        .st_eop(st_eop),
        .m_address(m_address),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .state(state),
        .bytes_written(bytes_written),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Slave-side monitor: log every completed write.
    always @(posedge clk) begin
        if (!reset && m_write && !m_waitrequest) begin
            wr_addr.push_back(m_address);
            wr_data.push_back(m_writedata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
    endtask

    function automatic logic [31:0] logAddr(input int idx);
        return (idx < wr_addr.size()) ? wr_addr[idx] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] logData(input int idx);
        return (idx < wr_data.size()) ? wr_data[idx] : 32'hFFFF_FFFF;
    endfunction

    task automatic doStart(input logic [31:0] base, input logic [31:0] len);
        base_addr = base;
        max_len   = len;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [31:0] d, input logic sop, input logic eop);
        int n;
        n        = 0;
        st_valid = 1'b1;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        #1;
        while (!st_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("beat_timeout", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (state != 2'b11 && n < 50) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(state), 32'd3);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        base_addr     = '0;
        max_len       = '0;
        st_valid      = 1'b0;
        st_data       = '0;
        st_sop        = 1'b0;
        st_eop        = 1'b0;
        m_waitrequest = 1'b0;
        #2;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_mwrite", 32'(m_write), 32'd0);
        checkOutput("rst_bytes", bytes_written, 32'd0);
        checkOutput("rst_ready", 32'(st_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic capture
        clearLog();
        doStart(32'h1000, 32'd64);
        checkOutput("basic_armed", 32'(state), 32'd1);
        checkOutput("basic_armed_ready", 32'(st_ready), 32'd1);
        applyStimulus(32'hD000_0000, 1'b1, 1'b0);
        checkOutput("basic_capture", 32'(state), 32'd2);
        checkOutput("basic_first_write", 32'(m_write), 32'd1);
        checkOutput("basic_first_addr", m_address, 32'h1000);
        applyStimulus(32'hD000_0001, 1'b0, 1'b0);
        applyStimulus(32'hD000_0002, 1'b0, 1'b0);
        applyStimulus(32'hD000_0003, 1'b0, 1'b1);
        waitDone("basic_done");
        checkOutput("basic_nwrites", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("basic_addr", logAddr(i), 32'h1000 + 32'(i * 4));
            checkOutput("basic_data", logData(i), 32'hD000_0000 + 32'(i));
        end
        checkOutput("basic_bytes", bytes_written, 32'd16);
        checkOutput("basic_ovf", 32'(overflow), 32'd0);
        checkOutput("done_ready", 32'(st_ready), 32'd0);

        // Junk before sop
        clearLog();
        doStart(32'h2000, 32'd64);
        applyStimulus(32'hBAD0_0000, 1'b0, 1'b0);
        applyStimulus(32'hBAD0_0001, 1'b0, 1'b0);
        applyStimulus(32'hBAD0_0002, 1'b0, 1'b1);
        checkOutput("junk_still_armed", 32'(state), 32'd1);
        checkOutput("junk_no_write", 32'(m_write), 32'd0);
        applyStimulus(32'hA000_0000, 1'b1, 1'b0);
        applyStimulus(32'hA000_0001, 1'b0, 1'b1);
        waitDone("junk_done");
        checkOutput("junk_nwrites", 32'(wr_addr.size()), 32'd2);
        checkOutput("junk_addr0", logAddr(0), 32'h2000);
        checkOutput("junk_addr1", logAddr(1), 32'h2004);
        checkOutput("junk_data1", logData(1), 32'hA000_0001);
        checkOutput("junk_bytes", bytes_written, 32'd8);

        // Backpressure on the second write
        clearLog();
        doStart(32'h3000, 32'd64);
        applyStimulus(32'hB000_0000, 1'b1, 1'b0);
        applyStimulus(32'hB000_0001, 1'b0, 1'b0);
        m_waitrequest = 1'b1;
        st_valid      = 1'b1;
        st_data       = 32'hB000_0002;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_mwrite", 32'(m_write), 32'd1);
            checkOutput("bp_addr", m_address, 32'h3004);
            checkOutput("bp_data", m_writedata, 32'hB000_0001);
            checkOutput("bp_ready", 32'(st_ready), 32'd0);
            tick();
        end
        m_waitrequest = 1'b0;
        applyStimulus(32'hB000_0002, 1'b0, 1'b0);
        applyStimulus(32'hB000_0003, 1'b0, 1'b1);
        waitDone("bp_done");
        checkOutput("bp_nwrites", 32'(wr_addr.size()), 32'd4);
        checkOutput("bp_addr2", logAddr(2), 32'h3008);
        checkOutput("bp_data2", logData(2), 32'hB000_0002);
        checkOutput("bp_addr3", logAddr(3), 32'h300C);
        checkOutput("bp_data3", logData(3), 32'hB000_0003);
        checkOutput("bp_bytes", bytes_written, 32'd16);

        // Overflow: two-word buffer, five-beat packet
        clearLog();
        doStart(32'h4000, 32'd8);
        applyStimulus(32'hC000_0000, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) applyStimulus(32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        applyStimulus(32'hC000_0004, 1'b0, 1'b1);
        waitDone("ovf_done");
        checkOutput("ovf_nwrites", 32'(wr_addr.size()), 32'd2);
        checkOutput("ovf_data1", logData(1), 32'hC000_0001);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_bytes", bytes_written, 32'd8);

        // Abort while a write is stalled
        clearLog();
        doStart(32'h5000, 32'd64);
        applyStimulus(32'hE000_0000, 1'b1, 1'b0);
        m_waitrequest = 1'b1;
        abort         = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_hold_state", 32'(state), 32'd2);
        checkOutput("abort_hold_write", 32'(m_write), 32'd1);
        checkOutput("abort_hold_ready", 32'(st_ready), 32'd0);
        tick();
        m_waitrequest = 1'b0;
        tick();
        checkOutput("abort_idle", 32'(state), 32'd0);
        checkOutput("abort_ready", 32'(st_ready), 32'd0);
        checkOutput("abort_nwrites", 32'(wr_addr.size()), 32'd1);
        checkOutput("abort_addr", logAddr(0), 32'h5000);
        checkOutput("abort_bytes", bytes_written, 32'd4);
        clearLog();
        doStart(32'h6000, 32'd64);
        applyStimulus(32'hF000_0000, 1'b1, 1'b0);
        applyStimulus(32'hF000_0001, 1'b0, 1'b1);
        waitDone("rearm_done");
        checkOutput("rearm_addr0", logAddr(0), 32'h6000);
        checkOutput("rearm_addr1", logAddr(1), 32'h6004);
        checkOutput("rearm_bytes", bytes_written, 32'd8);

        // Buffer smaller than one word
        clearLog();
        doStart(32'h7000, 32'd3);
        checkOutput("zero_done", 32'(state), 32'd3);
        checkOutput("zero_bytes", bytes_written, 32'd0);
        tick();
        checkOutput("zero_nwrites", 32'(wr_addr.size()), 32'd0);

        // Asynchronous reset mid-capture
        doStart(32'h8000, 32'd64);
        applyStimulus(32'h9000_0000, 1'b1, 1'b0);
        checkOutput("prerst_write", 32'(m_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_state", 32'(state), 32'd0);
        checkOutput("arst_mwrite", 32'(m_write), 32'd0);
        checkOutput("arst_addr", m_address, 32'd0);
        checkOutput("arst_data", m_writedata, 32'd0);
        checkOutput("arst_bytes", bytes_written, 32'd0);
        checkOutput("arst_ready", 32'(st_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
